// File: rtl/prbs_pkg.sv
// Shared constants and types for the PRBS checker and its bench models.
// Defaults match the N=20 Fibonacci generator with taps at stages 2 and 19.
package prbs_pkg;

    localparam int PRBS_N = 20;
    localparam logic [PRBS_N-1:0] PRBS_TAP_MASK = 20'hA0001;

    typedef enum logic [0:0] {
        HUNT  = 1'b0,
        CHECK = 1'b1
    } chk_state_t;

endpackage

// File: rtl/prbs_predictor.sv
// History shift register of received bits plus masked XOR prediction.
// Also usable as a Fibonacci-form reference generator by feeding pred back.
module prbs_predictor #(
    parameter int N = 20,
    parameter logic [N-1:0] TAP_MASK = 20'hA0001
) (
    input  logic         clk,
    input  logic         r,
    input  logic         shift,
    input  logic         din,
    output logic [N-1:0] hist,
    output logic         pred
);

    logic [N-1:0] hist_q;

    always_ff @(posedge clk) begin
        if (r) begin
            hist_q <= '0;
        end else if (shift) begin
            hist_q <= {hist_q[N-2:0], din};
        end
    end

    assign hist = hist_q;
    assign pred = ^(hist_q & TAP_MASK);

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS checker: hunts for a fill, then flags bits that
// break the LFSR recurrence and drops lock on a bad error-rate window.
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int N = PRBS_N,
    parameter logic [N-1:0] TAP_MASK = PRBS_TAP_MASK,
    parameter int WINDOW = 64,
    parameter int THRESH = 8,
    parameter int ERR_W = 16
) (
    input  logic             clk,
    input  logic             r,
    input  logic             din,
    input  logic             din_valid,
    input  logic             clr_count,
    output logic             locked,
    output logic             err,
    output logic [ERR_W-1:0] err_count
);

    localparam int FILL_W = $clog2(N + 1);
    localparam int WC_W = $clog2(WINDOW + 1);
    localparam int WE_W = $clog2(THRESH + 1);

    chk_state_t state, state_d;
    logic [FILL_W-1:0] fill, fill_d, fill_inc;
    logic [WC_W-1:0] win_cnt, win_cnt_d, win_cnt_inc;
    logic [WE_W-1:0] win_err, win_err_d, win_err_inc;
    logic err_d;

    logic [N-1:0] hist;
    logic [N-1:0] hist_next;
    logic pred;
    logic mismatch;
    logic hist_zero;
    logic count_hit;

    prbs_predictor #(
        .N(N),
        .TAP_MASK(TAP_MASK)
    ) u_pred (
        .clk(clk),
        .r(r),
        .shift(din_valid),
        .din(din),
        .hist(hist),
        .pred(pred)
    );

    assign hist_next = {hist[N-2:0], din};
    assign hist_zero = (hist_next == '0);
    assign mismatch = din ^ pred;

    assign fill_inc = fill + FILL_W'(1);
    assign win_cnt_inc = win_cnt + WC_W'(1);
    assign win_err_inc = win_err + WE_W'(mismatch);

    assign count_hit = din_valid && (state == CHECK) && mismatch;

    always_comb begin
        state_d = state;
        fill_d = fill;
        win_cnt_d = win_cnt;
        win_err_d = win_err;
        err_d = 1'b0;
        if (din_valid) begin
            unique case (state)
                HUNT: begin
                    if (fill_inc == FILL_W'(N)) begin
                        fill_d = '0;
                        if (!hist_zero) begin
                            state_d = CHECK;
                            win_cnt_d = '0;
                            win_err_d = '0;
                        end
                    end else begin
                        fill_d = fill_inc;
                    end
                end
                CHECK: begin
                    err_d = mismatch;
                    // threshold is tested before a closing window clears
                    if (win_err_inc >= WE_W'(THRESH) || hist_zero) begin
                        state_d = HUNT;
                        fill_d = '0;
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end else if (win_cnt_inc == WC_W'(WINDOW)) begin
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end else begin
                        win_cnt_d = win_cnt_inc;
                        win_err_d = win_err_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (r) begin
            state <= HUNT;
            fill <= '0;
            win_cnt <= '0;
            win_err <= '0;
            err <= 1'b0;
            locked <= 1'b0;
        end else begin
            state <= state_d;
            fill <= fill_d;
            win_cnt <= win_cnt_d;
            win_err <= win_err_d;
            err <= err_d;
            locked <= (state_d == CHECK);
        end
    end

    always_ff @(posedge clk) begin
        if (r || clr_count) begin
            err_count <= '0;
        end else if (count_hit && (err_count != {ERR_W{1'b1}})) begin
            err_count <= err_count + ERR_W'(1);
        end
    end

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: lock, error flagging, loss of lock,
// valid gaps, counter clear and mid-lock reset.
module tb_prbs_checker;

    logic clk = 1'b0;
    logic r = 1'b1;
    logic din = 1'b0;
    logic din_valid = 1'b0;
    logic clr_count = 1'b0;
    logic locked;
    logic err;
    logic [15:0] err_count;

    int pass_cnt = 0;
    int total_cnt = 0;

    bit strm [0:399];

    prbs_checker #(
        .N(20),
        .TAP_MASK(20'hA0001),
        .WINDOW(64),
        .THRESH(8),
        .ERR_W(16)
    ) dut (
        .clk(clk),
        .r(r),
        .din(din),
        .din_valid(din_valid),
        .clr_count(clr_count),
        .locked(locked),
        .err(err),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    // one clock: drive, let the edge take it, land on the next falling edge
    task automatic step(input logic b, input logic v);
        din = b;
        din_valid = v;
        @(negedge clk);
    endtask

    task automatic do_reset();
        r = 1'b1;
        clr_count = 1'b0;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        r = 1'b0;
    endtask

    // seed 20'h00001 shifted out MSB first, then b[n]=b[n-1]^b[n-18]^b[n-20]
    task automatic gen_clean();
        logic [19:0] seed;
        seed = 20'h00001;
        strm[0] = 1'b0;
        for (int i = 1; i <= 20; i++) strm[i] = seed[20-i];
        for (int i = 21; i < 400; i++)
            strm[i] = strm[i-1] ^ strm[i-18] ^ strm[i-20];
    endtask

    task automatic test_reset();
        do_reset();
        total_cnt++;
        if (locked !== 1'b0) $display("FAIL reset_locked: got %b want 0", locked);
        else pass_cnt++;
        total_cnt++;
        if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err);
        else pass_cnt++;
        total_cnt++;
        if (err_count !== 16'd0) $display("FAIL reset_count: got %0d want 0", err_count);
        else pass_cnt++;
    endtask

    task automatic test_clean_lock();
        int errs;
        errs = 0;
        do_reset();
        gen_clean();
        for (int n = 1; n <= 200; n++) begin
            step(strm[n], 1'b1);
            if (err) errs++;
            if (n == 19) begin
                total_cnt++;
                if (locked !== 1'b0) $display("FAIL clean_lock19: got %b want 0", locked);
                else pass_cnt++;
            end
            if (n == 20) begin
                total_cnt++;
                if (locked !== 1'b1) $display("FAIL clean_lock20: got %b want 1", locked);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (errs != 0) $display("FAIL clean_err: got %0d pulses want 0", errs);
        else pass_cnt++;
        total_cnt++;
        if (err_count !== 16'd0) $display("FAIL clean_count: got %0d want 0", err_count);
        else pass_cnt++;
    endtask

    task automatic test_single_flip();
        logic [255:0] emap, xmap;
        bit drop;
        emap = '0;
        xmap = '0;
        xmap[100] = 1'b1;
        xmap[101] = 1'b1;
        xmap[118] = 1'b1;
        xmap[120] = 1'b1;
        drop = 1'b0;
        do_reset();
        gen_clean();
        strm[100] = ~strm[100];
        for (int n = 1; n <= 200; n++) begin
            step(strm[n], 1'b1);
            if (err) emap[n] = 1'b1;
            if (n > 20 && !locked) drop = 1'b1;
        end
        total_cnt++;
        if (emap !== xmap) $display("FAIL flip_map: got %h want %h", emap, xmap);
        else pass_cnt++;
        total_cnt++;
        if (err_count !== 16'd4) $display("FAIL flip_count: got %0d want 4", err_count);
        else pass_cnt++;
        total_cnt++;
        if (drop) $display("FAIL flip_lock: got drop=1 want 0");
        else pass_cnt++;
    endtask

    task automatic test_burst();
        int st, fill, wc, we, mcnt;
        int first_fall, fall_n, rise_n;
        logic p, e_err, e_lock, prev;
        bit nz;
        st = 0; fill = 0; wc = 0; we = 0; mcnt = 0;
        first_fall = 0; fall_n = 0; rise_n = 0;
        prev = 1'b0;
        do_reset();
        gen_clean();
        for (int n = 100; n <= 163; n++) strm[n] = bit'($urandom_range(0, 1));
        for (int n = 1; n <= 330; n++) begin
            nz = 1'b0;
            for (int k = n - 19; k <= n; k++)
                if (k >= 1 && strm[k]) nz = 1'b1;
            e_err = 1'b0;
            if (st == 0) begin
                fill++;
                if (fill == 20) begin
                    fill = 0;
                    if (nz) begin st = 1; wc = 0; we = 0; end
                end
            end else begin
                p = strm[n-1] ^ strm[n-18] ^ strm[n-20];
                e_err = strm[n] ^ p;
                mcnt += int'(e_err);
                we += int'(e_err);
                wc++;
                if (we >= 8 || !nz) begin
                    st = 0; fill = 0; wc = 0; we = 0;
                end else if (wc == 64) begin
                    wc = 0; we = 0;
                end
            end
            e_lock = (st == 1);
            step(strm[n], 1'b1);
            total_cnt++;
            if (locked !== e_lock) $display("FAIL burst_locked bit %0d: got %b want %b", n, locked, e_lock);
            else pass_cnt++;
            total_cnt++;
            if (err !== e_err) $display("FAIL burst_err bit %0d: got %b want %b", n, err, e_err);
            else pass_cnt++;
            if (prev && !locked) begin
                fall_n = n;
                if (first_fall == 0) first_fall = n;
            end
            if (!prev && locked && fall_n != 0) rise_n = n;
            prev = locked;
        end
        total_cnt++;
        if (first_fall < 100 || first_fall > 163)
            $display("FAIL burst_drop: got first drop at bit %0d want 100..163", first_fall);
        else pass_cnt++;
        total_cnt++;
        if (rise_n != fall_n + 20)
            $display("FAIL burst_relock: got rise at %0d want %0d", rise_n, fall_n + 20);
        else pass_cnt++;
        total_cnt++;
        if (locked !== 1'b1) $display("FAIL burst_final_lock: got %b want 1", locked);
        else pass_cnt++;
        total_cnt++;
        if (err_count !== 16'(mcnt)) $display("FAIL burst_count: got %0d want %0d", err_count, mcnt);
        else pass_cnt++;
    endtask

    task automatic test_all_zero();
        bit any_l, any_e;
        any_l = 1'b0;
        any_e = 1'b0;
        do_reset();
        for (int n = 1; n <= 100; n++) begin
            step(1'b0, 1'b1);
            if (locked) any_l = 1'b1;
            if (err) any_e = 1'b1;
        end
        total_cnt++;
        if (any_l) $display("FAIL zero_locked: got 1 want 0");
        else pass_cnt++;
        total_cnt++;
        if (any_e) $display("FAIL zero_err: got 1 want 0");
        else pass_cnt++;
        gen_clean();
        for (int n = 1; n <= 20; n++) begin
            step(strm[n], 1'b1);
            if (n == 19) begin
                total_cnt++;
                if (locked !== 1'b0) $display("FAIL zero_relock19: got %b want 0", locked);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (locked !== 1'b1) $display("FAIL zero_relock20: got %b want 1", locked);
        else pass_cnt++;
    endtask

    task automatic test_valid_gaps();
        int errs;
        bit early;
        errs = 0;
        early = 1'b0;
        do_reset();
        gen_clean();
        for (int n = 1; n <= 200; n++) begin
            while ($urandom_range(0, 1) == 1) begin
                step(bit'($urandom_range(0, 1)), 1'b0);
                if (err) errs++;
                if (n <= 20 && locked) early = 1'b1;
            end
            step(strm[n], 1'b1);
            if (err) errs++;
            if (n < 20 && locked) early = 1'b1;
            if (n == 20) begin
                total_cnt++;
                if (locked !== 1'b1) $display("FAIL gaps_lock20: got %b want 1", locked);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (early) $display("FAIL gaps_early_lock: got 1 want 0");
        else pass_cnt++;
        total_cnt++;
        if (errs != 0) $display("FAIL gaps_err: got %0d pulses want 0", errs);
        else pass_cnt++;
        total_cnt++;
        if (err_count !== 16'd0) $display("FAIL gaps_count: got %0d want 0", err_count);
        else pass_cnt++;
    endtask

    task automatic test_clr_count();
        do_reset();
        gen_clean();
        strm[100] = ~strm[100];
        for (int n = 1; n <= 119; n++) step(strm[n], 1'b1);
        total_cnt++;
        if (err_count !== 16'd3) $display("FAIL clr_before: got %0d want 3", err_count);
        else pass_cnt++;
        clr_count = 1'b1;
        step(strm[120], 1'b1);
        clr_count = 1'b0;
        total_cnt++;
        if (err !== 1'b1) $display("FAIL clr_err: got %b want 1", err);
        else pass_cnt++;
        total_cnt++;
        if (err_count !== 16'd0) $display("FAIL clr_after: got %0d want 0", err_count);
        else pass_cnt++;
        total_cnt++;
        if (locked !== 1'b1) $display("FAIL clr_locked: got %b want 1", locked);
        else pass_cnt++;
        for (int n = 121; n <= 140; n++) step(strm[n], 1'b1);
        total_cnt++;
        if (err_count !== 16'd0) $display("FAIL clr_later: got %0d want 0", err_count);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        gen_clean();
        strm[40] = ~strm[40];
        for (int n = 1; n <= 70; n++) step(strm[n], 1'b1);
        total_cnt++;
        if (err_count !== 16'd4) $display("FAIL rmid_before: got %0d want 4", err_count);
        else pass_cnt++;
        r = 1'b1;
        step(strm[71], 1'b1);
        r = 1'b0;
        total_cnt++;
        if (locked !== 1'b0) $display("FAIL rmid_locked: got %b want 0", locked);
        else pass_cnt++;
        total_cnt++;
        if (err_count !== 16'd0) $display("FAIL rmid_count: got %0d want 0", err_count);
        else pass_cnt++;
        for (int n = 71; n <= 90; n++) begin
            step(strm[n], 1'b1);
            if (n == 89) begin
                total_cnt++;
                if (locked !== 1'b0) $display("FAIL rmid_refill19: got %b want 0", locked);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (locked !== 1'b1) $display("FAIL rmid_refill20: got %b want 1", locked);
        else pass_cnt++;
        for (int n = 91; n <= 130; n++) step(strm[n], 1'b1);
        total_cnt++;
        if (err_count !== 16'd0) $display("FAIL rmid_clean: got %0d want 0", err_count);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_clean_lock();
        test_single_flip();
        test_burst();
        test_all_zero();
        test_valid_gaps();
        test_clr_count();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
